// File: rtl/sparc_window_regfile_if.sv
// Operand/writeback/window-control bundle for the windowed SPARC register file.
// The master side is the pipeline; the slave side is the register file itself.
interface sparc_window_regfile_if #(
  parameter int NWINDOWS = 4
);
  localparam int CW = $clog2(NWINDOWS);

  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic                we;
  logic [31:0]         wdata;
  logic                save;
  logic                restore;
  logic                cwp_we;
  logic [CW-1:0]       cwp_in;
  logic [NWINDOWS-1:0] wim;
  logic [31:0]         rdata1;
  logic [31:0]         rdata2;
  logic [CW-1:0]       cwp;
  logic                win_overflow;
  logic                win_underflow;

  modport master (
    output rs1, rs2, rd, we, wdata, save, restore, cwp_we, cwp_in, wim,
    input  rdata1, rdata2, cwp, win_overflow, win_underflow
  );

  modport slave (
    input  rs1, rs2, rd, we, wdata, save, restore, cwp_we, cwp_in, wim,
    output rdata1, rdata2, cwp, win_overflow, win_underflow
  );
endinterface

// File: rtl/sparc_window_regfile.sv
// SPARC V8 windowed integer register file: 8 globals, NWINDOWS overlapping
// 16-register windows, CWP rotation with WIM overflow/underflow trap pulses.
module sparc_window_regfile #(
  parameter int NWINDOWS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sparc_window_regfile_if.slave  bus
);
  localparam int CW    = $clog2(NWINDOWS);
  localparam int NPHYS = 8 + 16 * NWINDOWS;
  localparam int PW    = $clog2(NPHYS);

  logic [31:0]   regs_r [NPHYS];
  logic [CW-1:0] cwp_r;
  logic          ovf_r;
  logic          unf_r;

  logic [CW-1:0] cwp_nxt_s;
  logic [CW-1:0] cwp_dec_s;
  logic [CW-1:0] cwp_inc_s;
  logic          ovf_nxt_s;
  logic          unf_nxt_s;
  logic [31:0]   rdata1_s;
  logic [31:0]   rdata2_s;

  // Window offset is taken modulo 16*NWINDOWS by truncating to CW+4 bits,
  // which gives the ins-of-window-(w-1) == outs-of-window-w overlap for free.
  function automatic logic [PW-1:0] phys_addr(input logic [4:0] r, input logic [CW-1:0] c);
    logic [CW+3:0] off;
    off = {c, 4'b0000} + (CW+4)'(r - 5'd8);
    if (r < 5'd8) begin
      phys_addr = PW'(r);
    end else begin
      phys_addr = PW'(5'd8) + PW'(off);
    end
  endfunction

  function automatic logic [31:0] read_port(input logic [4:0] rs, input logic [CW-1:0] c,
                                            input logic w_en, input logic [4:0] w_addr,
                                            input logic [31:0] w_data,
                                            input logic [31:0] stored);
    if (rs == 5'd0) begin
      read_port = 32'd0;
    end else if (w_en && (w_addr == rs)) begin
      read_port = w_data;
    end else begin
      read_port = stored;
    end
  endfunction

  assign cwp_dec_s = cwp_r - CW'(1'b1);
  assign cwp_inc_s = cwp_r + CW'(1'b1);

  // Combinational read ports with same-cycle write-through bypass.
  always_comb begin
    rdata1_s = read_port(bus.rs1, cwp_r, bus.we, bus.rd, bus.wdata,
                         regs_r[phys_addr(bus.rs1, cwp_r)]);
    rdata2_s = read_port(bus.rs2, cwp_r, bus.we, bus.rd, bus.wdata,
                         regs_r[phys_addr(bus.rs2, cwp_r)]);
  end

  // Next CWP and trap selection: direct load beats save, save beats restore.
  always_comb begin
    cwp_nxt_s = cwp_r;
    ovf_nxt_s = 1'b0;
    unf_nxt_s = 1'b0;
    if (bus.cwp_we) begin
      cwp_nxt_s = bus.cwp_in;
    end else if (bus.save) begin
      if (bus.wim[cwp_dec_s]) begin
        ovf_nxt_s = 1'b1;
      end else begin
        cwp_nxt_s = cwp_dec_s;
      end
    end else if (bus.restore) begin
      if (bus.wim[cwp_inc_s]) begin
        unf_nxt_s = 1'b1;
      end else begin
        cwp_nxt_s = cwp_inc_s;
      end
    end else begin
      cwp_nxt_s = cwp_r;
    end
  end

  // Register array; the write address uses the pre-update CWP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NPHYS; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (bus.we && (bus.rd != 5'd0)) begin
      regs_r[phys_addr(bus.rd, cwp_r)] <= bus.wdata;
    end
  end

  // CWP and one-cycle trap pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cwp_r <= '0;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
    end else begin
      cwp_r <= cwp_nxt_s;
      ovf_r <= ovf_nxt_s;
      unf_r <= unf_nxt_s;
    end
  end

  assign bus.rdata1        = rdata1_s;
  assign bus.rdata2        = rdata2_s;
  assign bus.cwp           = cwp_r;
  assign bus.win_overflow  = ovf_r;
  assign bus.win_underflow = unf_r;
endmodule

// File: tb/tb_sparc_window_regfile.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_sparc_window_regfile;
  localparam int NW = 4;
  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_CWP = 2;
  localparam int SEL_OVF = 3;
  localparam int SEL_UNF = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sparc_window_regfile_if #(.NWINDOWS(NW)) bus ();
  sparc_window_regfile #(.NWINDOWS(NW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RD1: observe = bus.rdata1;
      SEL_RD2: observe = bus.rdata2;
      SEL_CWP: observe = 32'(bus.cwp);
      SEL_OVF: observe = 32'(bus.win_overflow);
      SEL_UNF: observe = 32'(bus.win_underflow);
      default: observe = 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: drains every queued expectation at each falling edge.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = observe(e.sel);
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input int sel, input logic [31:0] v, input string n);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.rd = 5'd0; bus.wdata = 32'd0;
    bus.save = 1'b0; bus.restore = 1'b0; bus.cwp_we = 1'b0; bus.cwp_in = 2'd0;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    bus.we = 1'b1; bus.rd = r; bus.wdata = d;
    step();
    idle();
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.wim = 4'b0000;
    idle();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: all registers zero after reset, r0 hardwired
    expect_v(SEL_CWP, 32'd0, "reset_cwp");
    expect_v(SEL_OVF, 32'd0, "reset_ovf");
    expect_v(SEL_UNF, 32'd0, "reset_unf");
    for (int r = 0; r < 32; r++) begin
      bus.rs1 = 5'(r); bus.rs2 = 5'(31 - r);
      expect_v(SEL_RD1, 32'd0, "reset_rd1");
      expect_v(SEL_RD2, 32'd0, "reset_rd2");
      step();
    end
    bus.we = 1'b1; bus.rd = 5'd0; bus.wdata = 32'hFFFF_FFFF; bus.rs1 = 5'd0;
    expect_v(SEL_RD1, 32'd0, "r0_no_bypass");
    step();
    idle();
    expect_v(SEL_RD1, 32'd0, "r0_write_dropped");
    step();

    // 2: outs of window 0 alias ins of window 3
    write_reg(5'd8, 32'h1111_0008);
    bus.save = 1'b1; step(); idle();
    bus.rs1 = 5'd24;
    expect_v(SEL_CWP, 32'd3, "save_cwp_wrap");
    expect_v(SEL_RD1, 32'h1111_0008, "outs_alias_ins");
    bus.restore = 1'b1; step(); idle();
    bus.rs1 = 5'd8;
    expect_v(SEL_CWP, 32'd0, "restore_cwp_wrap");
    expect_v(SEL_RD1, 32'h1111_0008, "r8_after_restore");
    step();

    // 3: locals are private per window
    write_reg(5'd16, 32'hA5A5_0010);
    bus.save = 1'b1; step(); idle();
    bus.rs2 = 5'd16;
    expect_v(SEL_RD2, 32'd0, "new_window_locals");
    bus.restore = 1'b1; step(); idle();
    expect_v(SEL_RD2, 32'hA5A5_0010, "locals_restored");
    step();

    // 4: overflow / underflow trap pulses
    bus.wim = 4'b1000; bus.save = 1'b1; step(); idle();
    expect_v(SEL_CWP, 32'd0, "ovf_cwp_hold");
    expect_v(SEL_OVF, 32'd1, "ovf_pulse");
    expect_v(SEL_UNF, 32'd0, "ovf_no_unf");
    step();
    expect_v(SEL_OVF, 32'd0, "ovf_one_cycle");
    bus.cwp_we = 1'b1; bus.cwp_in = 2'd3; step(); idle();
    expect_v(SEL_CWP, 32'd3, "cwp_load_3");
    bus.wim = 4'b0001; bus.restore = 1'b1; step(); idle();
    expect_v(SEL_CWP, 32'd3, "unf_cwp_hold");
    expect_v(SEL_UNF, 32'd1, "unf_pulse");
    expect_v(SEL_OVF, 32'd0, "unf_no_ovf");
    step();
    expect_v(SEL_UNF, 32'd0, "unf_one_cycle");
    bus.wim = 4'b0000; bus.save = 1'b1; bus.restore = 1'b1; step(); idle();
    expect_v(SEL_CWP, 32'd2, "save_beats_restore");
    step();

    // 5: bypass plus cwp_we overriding a trapping save
    bus.wim = 4'b1111;
    bus.cwp_we = 1'b1; bus.cwp_in = 2'd0; step(); idle();
    bus.we = 1'b1; bus.rd = 5'd5; bus.wdata = 32'hDEAD_BEEF; bus.rs1 = 5'd5;
    bus.save = 1'b1; bus.cwp_we = 1'b1; bus.cwp_in = 2'd2;
    expect_v(SEL_RD1, 32'hDEAD_BEEF, "bypass_global");
    step(); idle();
    expect_v(SEL_CWP, 32'd2, "cwp_we_priority");
    expect_v(SEL_OVF, 32'd0, "cwp_we_no_trap");
    expect_v(SEL_RD1, 32'hDEAD_BEEF, "global_committed");
    bus.we = 1'b1; bus.rd = 5'd20; bus.wdata = 32'h0000_2020; bus.rs2 = 5'd20;
    expect_v(SEL_RD2, 32'h0000_2020, "bypass_windowed");
    step(); idle();
    bus.wim = 4'b0000;

    // 6: asynchronous reset clears storage and discards in-flight work
    bus.cwp_we = 1'b1; bus.cwp_in = 2'd3; step(); idle();
    expect_v(SEL_CWP, 32'd3, "cwp_load_before_reset");
    write_reg(5'd31, 32'h0000_0031);
    bus.rs1 = 5'd31;
    expect_v(SEL_RD1, 32'h0000_0031, "r31_written");
    step();
    bus.we = 1'b1; bus.rd = 5'd30; bus.wdata = 32'h0000_0030; bus.save = 1'b1;
    bus.rs1 = 5'd15; bus.rs2 = 5'd5;
    #2 reset_n = 1'b0;
    expect_v(SEL_CWP, 32'd0, "reset_async_cwp");
    expect_v(SEL_RD1, 32'd0, "reset_async_phys15");
    expect_v(SEL_RD2, 32'd0, "reset_async_global");
    step();
    idle();
    reset_n = 1'b1;
    bus.cwp_we = 1'b1; bus.cwp_in = 2'd3; step(); idle();
    bus.rs1 = 5'd31; bus.rs2 = 5'd30;
    expect_v(SEL_CWP, 32'd3, "post_reset_cwp");
    expect_v(SEL_RD1, 32'd0, "post_reset_r31");
    expect_v(SEL_RD2, 32'd0, "post_reset_r30_dropped");
    step();

    for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sbq.size() > 0) begin
      $display("FAIL drain: got %0d pending, expected 0", sbq.size());
      miscompares += sbq.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
